// File: rtl/mips_mc_pkg.sv
// Shared types and constants for the multicycle MIPS controller: state encoding,
// opcode/funct fields, ALU codes, trap codes and the decoded control bundle.
package mips_mc_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned TRAP_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_ERR    = 4'd13,
        S_JAL    = 4'd14
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_SLT   = 2'b11
    } aluop_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [TRAP_W-1:0] TRAP_NONE = 2'b00;
    localparam logic [TRAP_W-1:0] TRAP_ILL  = 2'b01;
    localparam logic [TRAP_W-1:0] TRAP_BUS  = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       pcen;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       link;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        aluop_t     aluop;
    } ctrl_t;

    // R-type funct values the datapath ALU implements
    function automatic logic funct_legal(input logic [OP_W-1:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_SLT);
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_hs_if.sv
// Controller <-> datapath/memory bundle. The controller uses the master view,
// the datapath and memory side use the slave view.
interface mips_mc_ctrl_hs_if #(
    parameter int unsigned ALUCTL_W = 4
);
    logic [5:0]          op;
    logic [5:0]          funct;
    logic                zero;
    logic                mem_ready;
    logic                mem_req;
    logic                pcen;
    logic                memwrite;
    logic                irwrite;
    logic                regwrite;
    logic                alusrca;
    logic                iord;
    logic                memtoreg;
    logic                regdst;
    logic                link;
    logic [1:0]          alusrcb;
    logic [1:0]          pcsrc;
    logic [ALUCTL_W-1:0] alucontrol;
    logic [1:0]          trap;
    logic [3:0]          state_o;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, pcen, memwrite, irwrite, regwrite, alusrca, iord,
               memtoreg, regdst, link, alusrcb, pcsrc, alucontrol, trap, state_o
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, pcen, memwrite, irwrite, regwrite, alusrca, iord,
               memtoreg, regdst, link, alusrcb, pcsrc, alucontrol, trap, state_o
    );
endinterface

// File: rtl/mips_mc_aludec.sv
// ALU decoder: maps the controller's aluop class and the R-type funct field
// to a zero-extended ALU control code.
module mips_mc_aludec
    import mips_mc_pkg::*;
#(
    parameter int unsigned ALUCTL_W = 4
) (
    input  aluop_t              aluop,
    input  logic [5:0]          funct,
    output logic [ALUCTL_W-1:0] alucontrol
);
    logic [3:0] code;

    always_comb begin
        code = ALU_ADD;
        case (aluop)
            ALUOP_ADD: code = ALU_ADD;
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_SLT: code = ALU_SLT;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  code = ALU_ADD;
                    FN_SUB:  code = ALU_SUB;
                    FN_AND:  code = ALU_AND;
                    FN_OR:   code = ALU_OR;
                    FN_SLT:  code = ALU_SLT;
                    default: code = ALU_ADD;
                endcase
            end
            default: code = ALU_ADD;
        endcase
    end

    assign alucontrol = ALUCTL_W'(code);

endmodule

// File: rtl/mips_mc_ctrl_hs.sv
// Multicycle MIPS main controller with req/ready memory handshake, wait-state
// timeout and sticky trap. Define MIPS_MC_JAL_EN to decode JAL (op 000011).
module mips_mc_ctrl_hs
    import mips_mc_pkg::*;
#(
    parameter int unsigned ALUCTL_W = 4,
    parameter int unsigned WAIT_W   = 4,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    mips_mc_ctrl_hs_if.master bus
);
    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [TRAP_W-1:0]   trap_q, trap_d;
    ctrl_t               ctl;
    logic                timeout;

    assign timeout = (cnt_q == WAIT_W'(TIMEOUT)) && !bus.mem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            trap_q  <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trap_q  <= trap_d;
        end
    end

    // Next state and control decode; everything is forced low while reset is held
    always_comb begin
        state_d = state_q;
        trap_d  = trap_q;
        ctl     = '0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    ctl.mem_req = 1'b1;
                    ctl.alusrcb = SRCB_FOUR;
                    ctl.pcsrc   = PCSRC_ALU;
                    if (bus.mem_ready) begin
                        ctl.irwrite = 1'b1;
                        ctl.pcen    = 1'b1;
                        state_d     = S_DECODE;
                    end else if (timeout) begin
                        state_d = S_ERR;
                        trap_d  = TRAP_BUS;
                    end
                end
                S_DECODE: begin
                    ctl.alusrcb = SRCB_IMMSH;
                    case (bus.op)
                        OP_LW, OP_SW:     state_d = S_MEMADR;
                        OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                        OP_ADDI, OP_SLTI: state_d = S_IEXEC;
                        OP_J:             state_d = S_JUMP;
                        OP_RTYPE: begin
                            if (funct_legal(bus.funct)) begin
                                state_d = S_EXEC;
                            end else begin
                                state_d = S_ERR;
                                trap_d  = TRAP_ILL;
                            end
                        end
`ifdef MIPS_MC_JAL_EN
                        OP_JAL:           state_d = S_JAL;
`else
                        OP_JAL: begin
                            state_d = S_ERR;
                            trap_d  = TRAP_ILL;
                        end
`endif
                        default: begin
                            state_d = S_ERR;
                            trap_d  = TRAP_ILL;
                        end
                    endcase
                end
                S_MEMADR: begin
                    ctl.alusrca = 1'b1;
                    ctl.alusrcb = SRCB_IMM;
                    state_d     = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    ctl.mem_req = 1'b1;
                    ctl.iord    = 1'b1;
                    if (bus.mem_ready) begin
                        state_d = S_MEMWB;
                    end else if (timeout) begin
                        state_d = S_ERR;
                        trap_d  = TRAP_BUS;
                    end
                end
                S_MEMWB: begin
                    ctl.regwrite = 1'b1;
                    ctl.memtoreg = 1'b1;
                    state_d      = S_FETCH;
                end
                S_MEMWR: begin
                    ctl.mem_req  = 1'b1;
                    ctl.iord     = 1'b1;
                    ctl.memwrite = 1'b1;
                    if (bus.mem_ready) begin
                        state_d = S_FETCH;
                    end else if (timeout) begin
                        state_d = S_ERR;
                        trap_d  = TRAP_BUS;
                    end
                end
                S_EXEC: begin
                    ctl.alusrca = 1'b1;
                    ctl.alusrcb = SRCB_B;
                    ctl.aluop   = ALUOP_FUNCT;
                    state_d     = S_ALUWB;
                end
                S_ALUWB: begin
                    ctl.regwrite = 1'b1;
                    ctl.regdst   = 1'b1;
                    state_d      = S_FETCH;
                end
                S_BRANCH: begin
                    // op[0] distinguishes BNE from BEQ
                    ctl.alusrca = 1'b1;
                    ctl.alusrcb = SRCB_B;
                    ctl.aluop   = ALUOP_SUB;
                    ctl.pcsrc   = PCSRC_ALUOUT;
                    ctl.pcen    = bus.zero ^ bus.op[0];
                    state_d     = S_FETCH;
                end
                S_IEXEC: begin
                    ctl.alusrca = 1'b1;
                    ctl.alusrcb = SRCB_IMM;
                    ctl.aluop   = (bus.op == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
                    state_d     = S_IWB;
                end
                S_IWB: begin
                    ctl.regwrite = 1'b1;
                    state_d      = S_FETCH;
                end
                S_JUMP: begin
                    ctl.pcsrc = PCSRC_JUMP;
                    ctl.pcen  = 1'b1;
                    state_d   = S_FETCH;
                end
`ifdef MIPS_MC_JAL_EN
                S_JAL: begin
                    ctl.pcsrc    = PCSRC_JUMP;
                    ctl.pcen     = 1'b1;
                    ctl.regwrite = 1'b1;
                    ctl.link     = 1'b1;
                    state_d      = S_FETCH;
                end
`endif
                S_ERR:   state_d = S_ERR;
                default: state_d = S_ERR;
            endcase
        end
    end

    // Wait counter: clears on any state change or completed access
    always_comb begin
        cnt_d = '0;
        if (ctl.mem_req && !bus.mem_ready && (state_d == state_q)) begin
            cnt_d = cnt_q + WAIT_W'(1);
        end
    end

    mips_mc_aludec #(
        .ALUCTL_W (ALUCTL_W)
    ) u_aludec (
        .aluop      (ctl.aluop),
        .funct      (bus.funct),
        .alucontrol (bus.alucontrol)
    );

    assign bus.mem_req  = ctl.mem_req;
    assign bus.pcen     = ctl.pcen;
    assign bus.memwrite = ctl.memwrite;
    assign bus.irwrite  = ctl.irwrite;
    assign bus.regwrite = ctl.regwrite;
    assign bus.alusrca  = ctl.alusrca;
    assign bus.iord     = ctl.iord;
    assign bus.memtoreg = ctl.memtoreg;
    assign bus.regdst   = ctl.regdst;
    assign bus.link     = ctl.link;
    assign bus.alusrcb  = ctl.alusrcb;
    assign bus.pcsrc    = ctl.pcsrc;
    assign bus.trap     = trap_q;
    assign bus.state_o  = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl_hs.sv
// Scoreboard bench for mips_mc_ctrl_hs: directed per-cycle vectors push expected
// control words; a negedge monitor pops and compares them against the DUT.
module tb_mips_mc_ctrl_hs;

    localparam logic [9:0] MREQ = 10'b10_0000_0000;
    localparam logic [9:0] PCEN = 10'b01_0000_0000;
    localparam logic [9:0] IRW  = 10'b00_1000_0000;
    localparam logic [9:0] RW   = 10'b00_0100_0000;
    localparam logic [9:0] MW   = 10'b00_0010_0000;
    localparam logic [9:0] IORD = 10'b00_0001_0000;
    localparam logic [9:0] M2R  = 10'b00_0000_1000;
    localparam logic [9:0] RDST = 10'b00_0000_0100;
    localparam logic [9:0] ASA  = 10'b00_0000_0010;
    localparam logic [9:0] LINK = 10'b00_0000_0001;
    localparam logic [9:0] NONE = 10'b00_0000_0000;

    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_SLT = 4'b0111;

    localparam logic [5:0] O_R    = 6'b000000;
    localparam logic [5:0] O_LW   = 6'b100011;
    localparam logic [5:0] O_SW   = 6'b101011;
    localparam logic [5:0] O_BEQ  = 6'b000100;
    localparam logic [5:0] O_BNE  = 6'b000101;
    localparam logic [5:0] O_ADDI = 6'b001000;
    localparam logic [5:0] O_SLTI = 6'b001010;
    localparam logic [5:0] O_J    = 6'b000010;
    localparam logic [5:0] O_JAL  = 6'b000011;
    localparam logic [5:0] O_BAD  = 6'b111111;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [23:0] eq[$];
    string       nq[$];

    mips_mc_ctrl_hs_if #(.ALUCTL_W(4)) bus ();

    mips_mc_ctrl_hs #(
        .ALUCTL_W (4),
        .WAIT_W   (4),
        .TIMEOUT  (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected control word per cycle, sampled mid-cycle
    always @(negedge clk) begin
        logic [23:0] e;
        logic [23:0] act;
        string       nm;
        if (eq.size() > 0) begin
            e   = eq.pop_front();
            nm  = nq.pop_front();
            act = {bus.mem_req, bus.pcen, bus.irwrite, bus.regwrite, bus.memwrite,
                   bus.iord, bus.memtoreg, bus.regdst, bus.alusrca, bus.link,
                   bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.trap, bus.state_o};
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL %s: got flags=%b srcb=%b pcsrc=%b alu=%b trap=%b st=%0d want flags=%b srcb=%b pcsrc=%b alu=%b trap=%b st=%0d",
                         nm, act[23:14], act[13:12], act[11:10], act[9:6], act[5:4], act[3:0],
                         e[23:14], e[13:12], e[11:10], e[9:6], e[5:4], e[3:0]);
            end
        end
    end

    task automatic cyc(input string nm, input logic rs, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic r, input logic [9:0] fl, input logic [1:0] sb,
                       input logic [1:0] ps, input logic [3:0] alu, input logic [1:0] tr,
                       input logic [3:0] st);
        @(posedge clk);
        #1;
        reset         = rs;
        bus.op        = o;
        bus.funct     = f;
        bus.zero      = z;
        bus.mem_ready = r;
        eq.push_back({fl, sb, ps, alu, tr, st});
        nq.push_back(nm);
    endtask

    task automatic fetch_ok(input string nm, input logic [5:0] o, input logic [5:0] f);
        cyc(nm, 1'b1, o, f, 1'b0, 1'b1, MREQ | PCEN | IRW, 2'b01, 2'b00, A_ADD, 2'b00, 4'd0);
    endtask

    task automatic decode(input string nm, input logic [5:0] o, input logic [5:0] f);
        cyc(nm, 1'b1, o, f, 1'b0, 1'b1, NONE, 2'b11, 2'b00, A_ADD, 2'b00, 4'd1);
    endtask

    task automatic rtype(input string nm, input logic [5:0] f, input logic [3:0] alu);
        fetch_ok({nm, "_fetch"}, O_R, f);
        decode({nm, "_decode"}, O_R, f);
        cyc({nm, "_exec"}, 1'b1, O_R, f, 1'b0, 1'b1, ASA, 2'b00, 2'b00, alu, 2'b00, 4'd6);
        cyc({nm, "_wb"}, 1'b1, O_R, f, 1'b0, 1'b1, RW | RDST, 2'b00, 2'b00, A_ADD, 2'b00, 4'd7);
    endtask

    task automatic branch(input string nm, input logic [5:0] o, input logic z, input logic [9:0] fl);
        fetch_ok({nm, "_fetch"}, o, 6'd0);
        decode({nm, "_decode"}, o, 6'd0);
        cyc({nm, "_branch"}, 1'b1, o, 6'd0, z, 1'b1, fl, 2'b00, 2'b01, A_SUB, 2'b00, 4'd8);
    endtask

    task automatic rst_cycle(input string nm);
        cyc(nm, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, NONE, 2'b00, 2'b00, A_ADD, 2'b00, 4'd0);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b0;
        bus.op        = 6'd0;
        bus.funct     = 6'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;

        rst_cycle("reset_hold");
        cyc("fetch_after_reset", 1'b1, O_R, 6'd0, 1'b0, 1'b0, MREQ, 2'b01, 2'b00, A_ADD, 2'b00, 4'd0);
        cyc("fetch_wait", 1'b1, O_R, 6'd0, 1'b0, 1'b0, MREQ, 2'b01, 2'b00, A_ADD, 2'b00, 4'd0);
        rst_cycle("reset_mid_fetch");

        rtype("add", 6'b100000, A_ADD);
        rtype("sub", 6'b100010, A_SUB);
        rtype("and", 6'b100100, A_AND);
        rtype("or",  6'b100101, A_OR);
        rtype("slt", 6'b101010, A_SLT);

        // LW with three wait cycles in MEMRD
        fetch_ok("lw_fetch", O_LW, 6'd0);
        decode("lw_decode", O_LW, 6'd0);
        cyc("lw_memadr", 1'b1, O_LW, 6'd0, 1'b0, 1'b1, ASA, 2'b10, 2'b00, A_ADD, 2'b00, 4'd2);
        for (int i = 0; i < 3; i++)
            cyc("lw_wait", 1'b1, O_LW, 6'd0, 1'b0, 1'b0, MREQ | IORD, 2'b00, 2'b00, A_ADD, 2'b00, 4'd3);
        cyc("lw_done", 1'b1, O_LW, 6'd0, 1'b0, 1'b1, MREQ | IORD, 2'b00, 2'b00, A_ADD, 2'b00, 4'd3);
        cyc("lw_wb", 1'b1, O_LW, 6'd0, 1'b0, 1'b1, RW | M2R, 2'b00, 2'b00, A_ADD, 2'b00, 4'd4);

        fetch_ok("sw_fetch", O_SW, 6'd0);
        decode("sw_decode", O_SW, 6'd0);
        cyc("sw_memadr", 1'b1, O_SW, 6'd0, 1'b0, 1'b1, ASA, 2'b10, 2'b00, A_ADD, 2'b00, 4'd2);
        cyc("sw_memwr", 1'b1, O_SW, 6'd0, 1'b0, 1'b1, MREQ | IORD | MW, 2'b00, 2'b00, A_ADD, 2'b00, 4'd5);

        branch("bne_z0", O_BNE, 1'b0, PCEN | ASA);
        branch("beq_z0", O_BEQ, 1'b0, ASA);
        branch("beq_z1", O_BEQ, 1'b1, PCEN | ASA);
        branch("bne_z1", O_BNE, 1'b1, ASA);

        fetch_ok("addi_fetch", O_ADDI, 6'd0);
        decode("addi_decode", O_ADDI, 6'd0);
        cyc("addi_iexec", 1'b1, O_ADDI, 6'd0, 1'b0, 1'b1, ASA, 2'b10, 2'b00, A_ADD, 2'b00, 4'd9);
        cyc("addi_iwb", 1'b1, O_ADDI, 6'd0, 1'b0, 1'b1, RW, 2'b00, 2'b00, A_ADD, 2'b00, 4'd10);
        fetch_ok("slti_fetch", O_SLTI, 6'd0);
        decode("slti_decode", O_SLTI, 6'd0);
        cyc("slti_iexec", 1'b1, O_SLTI, 6'd0, 1'b0, 1'b1, ASA, 2'b10, 2'b00, A_SLT, 2'b00, 4'd9);
        cyc("slti_iwb", 1'b1, O_SLTI, 6'd0, 1'b0, 1'b1, RW, 2'b00, 2'b00, A_ADD, 2'b00, 4'd10);

        fetch_ok("j_fetch", O_J, 6'd0);
        decode("j_decode", O_J, 6'd0);
        cyc("j_jump", 1'b1, O_J, 6'd0, 1'b0, 1'b1, PCEN, 2'b00, 2'b10, A_ADD, 2'b00, 4'd11);

        // mem_ready arrives on the cycle the wait counter equals TIMEOUT
        for (int i = 0; i < 15; i++)
            cyc("edge_wait", 1'b1, O_J, 6'd0, 1'b0, 1'b0, MREQ, 2'b01, 2'b00, A_ADD, 2'b00, 4'd0);
        fetch_ok("edge_ready_at_limit", O_J, 6'd0);
        decode("edge_decode", O_J, 6'd0);
        cyc("edge_jump", 1'b1, O_J, 6'd0, 1'b0, 1'b1, PCEN, 2'b00, 2'b10, A_ADD, 2'b00, 4'd11);

        // mem_ready stuck low: 15 wait cycles, then the limit cycle, then ERR
        for (int i = 0; i < 16; i++)
            cyc("to_wait", 1'b1, O_J, 6'd0, 1'b0, 1'b0, MREQ, 2'b01, 2'b00, A_ADD, 2'b00, 4'd0);
        cyc("to_err", 1'b1, O_J, 6'd0, 1'b0, 1'b1, NONE, 2'b00, 2'b00, A_ADD, 2'b10, 4'd13);
        cyc("to_err_hold", 1'b1, O_J, 6'd0, 1'b1, 1'b1, NONE, 2'b00, 2'b00, A_ADD, 2'b10, 4'd13);
        rst_cycle("rst_clears_trap");

        fetch_ok("jal_fetch", O_JAL, 6'd0);
        decode("jal_decode", O_JAL, 6'd0);
`ifdef MIPS_MC_JAL_EN
        cyc("jal_exec", 1'b1, O_JAL, 6'd0, 1'b0, 1'b1, PCEN | RW | LINK, 2'b00, 2'b10, A_ADD, 2'b00, 4'd14);
        fetch_ok("jal_next_fetch", O_R, 6'b100000);
`else
        cyc("jal_illegal", 1'b1, O_JAL, 6'd0, 1'b0, 1'b1, NONE, 2'b00, 2'b00, A_ADD, 2'b01, 4'd13);
        cyc("jal_illegal_hold", 1'b1, O_J, 6'd0, 1'b0, 1'b1, NONE, 2'b00, 2'b00, A_ADD, 2'b01, 4'd13);
`endif
        rst_cycle("rst_after_jal");

        fetch_ok("badop_fetch", O_BAD, 6'd0);
        decode("badop_decode", O_BAD, 6'd0);
        cyc("badop_trap", 1'b1, O_BAD, 6'd0, 1'b0, 1'b1, NONE, 2'b00, 2'b00, A_ADD, 2'b01, 4'd13);
        rst_cycle("rst_after_badop");

        fetch_ok("badfn_fetch", O_R, 6'b000000);
        decode("badfn_decode", O_R, 6'b000000);
        cyc("badfn_trap", 1'b1, O_R, 6'b000000, 1'b0, 1'b1, NONE, 2'b00, 2'b00, A_ADD, 2'b01, 4'd13);
        rst_cycle("rst_after_badfn");
        fetch_ok("final_fetch", O_R, 6'b100000);

        @(posedge clk);
        for (int i = 0; i < 10 && eq.size() > 0; i++) @(posedge clk);
        if (eq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", eq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl_hs.md
Name: mips_mc_ctrl_hs

Overview:
Next-generation multicycle MIPS main controller: FSM plus ALU decoder driving the existing multicycle datapath select/enable lines.
Adds a req/ready memory handshake with a wait-state timeout in place of fixed single-cycle memory.
Adds BNE/SLTI support, illegal-instruction trapping and a parametrised ALU-control width.
Sits between the instruction register opcode/funct fields and the datapath, under the processor top level.

Parameters:
ALUCTL_W, 4, alucontrol width; codes are zero-extended to this width, minimum 4.
WAIT_W, 4, width of the memory wait counter.
TIMEOUT, 15, wait cycles without mem_ready before bus error; 1..2^WAIT_W-1.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
op  in  6  instruction opcode.
funct  in  6  instruction funct field.
zero  in  1  ALU zero flag.
mem_ready  in  1  memory completes the current access this cycle.
mem_req  out  1  memory access request.
pcen  out  1  PC write enable.
memwrite  out  1  memory write.
irwrite  out  1  instruction register write.
regwrite  out  1  register file write.
alusrca  out  1  0 = PC, 1 = A.
iord  out  1  0 = PC address, 1 = ALUOut address.
memtoreg  out  1  writeback from data register.
regdst  out  1  1 = rd, 0 = rt.
link  out  1  write PC into r31 (JAL); constant 0 when the feature is off.
alusrcb  out  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
alucontrol  out  ALUCTL_W  ALU operation.
trap  out  2  sticky error: 00 = none, 01 = illegal instruction, 10 = bus timeout.
state_o  out  4  current state, for debug.

Behaviour:
- Reset (reset=0, asynchronous): state is FETCH, wait counter is 0, trap is 00. Registered outputs are 0.
- All control outputs are Moore decodes of the state, except two that also use inputs:
  - pcen/irwrite in FETCH are gated by mem_ready.
  - pcen in BRANCH is gated by zero.
- Default for every output in every state: 0. alucontrol defaults to ADD (0010).
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
- States and transitions:
  - FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, ADD. On mem_ready: irwrite=1, pcen=1, go to DECODE. Otherwise stay.
  - DECODE: alusrca=0, alusrcb=11, ADD (branch target into ALUOut). Next state by op:
    - 100011/101011 (LW/SW) -> MEMADR
    - 000000 -> EXEC if funct is in {100000, 100010, 100100, 100101, 101010}, else ERR with trap=01
    - 000100/000101 (BEQ/BNE) -> BRANCH
    - 001000/001010 (ADDI/SLTI) -> IEXEC
    - 000010 (J) -> JUMP
    - any other op -> ERR with trap=01
  - MEMADR: alusrca=1, alusrcb=10, ADD. -> MEMRD for LW, MEMWR for SW.
  - MEMRD: mem_req=1, iord=1. Stay until mem_ready, then -> MEMWB.
  - MEMWB: regwrite=1, memtoreg=1, regdst=0. -> FETCH.
  - MEMWR: mem_req=1, iord=1, memwrite=1. Stay until mem_ready, then -> FETCH.
  - EXEC: alusrca=1, alusrcb=00, alucontrol from funct. -> ALUWB.
  - ALUWB: regwrite=1, regdst=1. -> FETCH.
  - BRANCH: alusrca=1, alusrcb=00, SUB, pcsrc=01, pcen = zero XOR op[0]. -> FETCH.
  - IEXEC: alusrca=1, alusrcb=10; ADD for ADDI, SLT for SLTI. -> IWB.
  - IWB: regwrite=1, regdst=0. -> FETCH.
  - JUMP: pcsrc=10, pcen=1. -> FETCH.
  - ERR: all enables 0, mem_req=0. Trap is held; only reset exits.
- Handshake and timeout:
  - mem_req stays high continuously in wait states. Address and data selects are stable while waiting.
  - The wait counter clears on entry to FETCH/MEMRD/MEMWR and on mem_ready. It increments each cycle mem_req=1 && mem_ready=0.
  - When the counter reaches TIMEOUT with mem_ready still 0: go to ERR, trap=10, and no enable pulses that cycle.
  - mem_ready on the same cycle the counter reaches TIMEOUT: mem_ready wins and the access completes.
  - mem_ready outside a request is ignored.
- Latency with zero-wait memory (mem_ready always 1), in cycles: R-type 4, LW 5, SW 4, branch 3, ADDI/SLTI 4, J 3.
- Reset asserted mid-access drops mem_req asynchronously; no partial enable is produced.

Optional Feature:
MIPS_MC_JAL_EN
- Defined: op 000011 decodes from DECODE to state JAL. JAL asserts pcsrc=10, pcen=1, regwrite=1, link=1, then -> FETCH; latency 3.
- Undefined: op 000011 is illegal (ERR, trap=01) and link is tied to 0.
- Port list is identical in both builds.

Decomposition:
- Package mips_mc_pkg holds:
  - the state enum, 4-bit encoding: FETCH=0 through ERR=13, JAL=14;
  - opcode and funct constants;
  - ALU code constants;
  - trap codes.
- One natural sub-module: mips_mc_aludec, combinational. Inputs are a 2-bit aluop (add / sub / funct / slt) and funct; output is alucontrol[ALUCTL_W-1:0].

Test Plan:
- Reset low mid-FETCH with mem_ready=0 -> immediately state_o=0, mem_req=0, trap=00. After release, FETCH with mem_req=1.
- R-type ADD (op=0, funct=100000), mem_ready=1 -> sequence FETCH, DECODE, EXEC (alucontrol=0010), ALUWB (regwrite=1, regdst=1); 4 cycles.
- LW with mem_ready held low for 3 cycles in MEMRD -> mem_req and iord stay 1 for 4 cycles, then MEMWB with memtoreg=1.
- BNE with zero=0 -> pcen=1, pcsrc=01 in BRANCH. BEQ with zero=0 -> pcen=0.
- TIMEOUT=15 and mem_ready stuck 0 in FETCH -> ERR after 15 wait cycles, trap=10, pcen/irwrite never pulse. Variant with mem_ready at cycle 15 -> access completes normally.
- op=000011 -> with MIPS_MC_JAL_EN: link=1, regwrite=1, pcsrc=10. Without it: trap=01. op=111111 -> trap=01 in both builds.
